// File: rtl/sub_pipe8_if.sv
// sub_pipe8_if: operand/result bundle for sub_pipe8 (upstream valid/ready + downstream valid/ready).
// Latency: none, wiring only.
// Backpressure: carries in_ready upstream and out_ready downstream; no storage of its own.
// Signals: in_valid/in_ready/A/B/bin form the input channel, out_valid/out_ready/diff/bout the output channel.
// master = producer/consumer side that drives operands and out_ready; slave = the subtractor.
interface sub_pipe8_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output in_valid, A, B, bin, out_ready,
      input  in_ready, out_valid, diff, bout
   );

   modport slave (
      input  in_valid, A, B, bin, out_ready,
      output in_ready, out_valid, diff, bout
   );
endinterface

// File: rtl/sub_pipe8.sv
// sub_pipe8: two-stage pipelined unsigned subtractor, diff = A - B - bin, bout = borrow-out.
// Latency: 2 cycles from input transfer to out_valid; throughput 1 op/cycle.
// Backpressure: out_ready low stalls stage 2, then stage 1; in_ready drops only when both are full.
// Ports: i_clk (rising edge), i_rst_n (async, active-low), bus (sub_pipe8_if.slave): operands
//        A/B/bin with in_valid/in_ready, results diff/bout with out_valid/out_ready.
// Build option: define SUB_PIPE8_SAT_EN to clamp diff to 0 on underflow (bout still reported).
module sub_pipe8 #(
   parameter int WIDTH = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   sub_pipe8_if.slave  bus
);
   localparam int LO = WIDTH / 2;
   localparam int HI = WIDTH - LO;

   if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
      $error("sub_pipe8: WIDTH must be even and >= 2");
   end

   // stage 1 state
   logic          r_s1_vld;
   logic [HI-1:0] r_a_hi;
   logic [HI-1:0] r_b_hi;
   logic [LO-1:0] r_d_lo;
   logic          r_b1;

   // stage 2 (output) state
   logic             r_out_vld;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;

   logic             w_en1;
   logic             w_en2;
   logic             w_in_xfer;
   logic [LO:0]      w_lo_res;
   logic [HI:0]      w_hi_res;
   logic [WIDTH-1:0] w_diff_nxt;

   // Stage 2 may load when its content leaves or it is empty; stage 1 likewise
   // when it can move forward or is empty, which collapses bubbles under stall.
   assign w_en2     = bus.out_ready | ~r_out_vld;
   assign w_en1     = w_en2 | ~r_s1_vld;
   assign w_in_xfer = bus.in_valid & w_en1;

   // Low half: borrow out of this (LO+1)-bit subtraction lands in the MSB.
   assign w_lo_res = {1'b0, bus.A[LO-1:0]} - {1'b0, bus.B[LO-1:0]} - {{LO{1'b0}}, bus.bin};

   // High half consumes the registered low-half borrow.
   assign w_hi_res = {1'b0, r_a_hi} - {1'b0, r_b_hi} - {{HI{1'b0}}, r_b1};

`ifdef SUB_PIPE8_SAT_EN
   assign w_diff_nxt = w_hi_res[HI] ? '0 : {w_hi_res[HI-1:0], r_d_lo};
`else
   assign w_diff_nxt = {w_hi_res[HI-1:0], r_d_lo};
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_vld <= 1'b0;
         r_a_hi   <= '0;
         r_b_hi   <= '0;
         r_d_lo   <= '0;
         r_b1     <= 1'b0;
      end else begin
         if (w_en1) begin
            r_s1_vld <= bus.in_valid;
         end
         if (w_in_xfer) begin
            r_a_hi <= bus.A[WIDTH-1:LO];
            r_b_hi <= bus.B[WIDTH-1:LO];
            r_d_lo <= w_lo_res[LO-1:0];
            r_b1   <= w_lo_res[LO];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_vld <= 1'b0;
         r_diff    <= '0;
         r_bout    <= 1'b0;
      end else begin
         if (w_en2) begin
            r_out_vld <= r_s1_vld;
         end
         if (w_en2 && r_s1_vld) begin
            r_diff <= w_diff_nxt;
            r_bout <= w_hi_res[HI];
         end
      end
   end

   assign bus.in_ready  = w_en1;
   assign bus.out_valid = r_out_vld;
   assign bus.diff      = r_diff;
   assign bus.bout      = r_bout;
endmodule

// File: tb/tb_sub_pipe8.sv
// tb_sub_pipe8: self-checking bench for sub_pipe8 (WIDTH=8) with a result scoreboard queue.
// Latency: n/a (bench).
// Backpressure: bench drives out_ready patterns to exercise stalls and bubble collapse.
module tb_sub_pipe8;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sub_pipe8_if #(.WIDTH(W)) bus();

   sub_pipe8 #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [W:0] exp_q[$];   // {bout, diff}

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      logic [W:0] full;
      full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
`ifdef SUB_PIPE8_SAT_EN
      if (full[W]) full[W-1:0] = '0;
`endif
      return full;
   endfunction

   // Drive one cycle of stimulus at the falling edge, push accepted ops to the
   // scoreboard, and report whether an output transfer is pending at the next edge.
   task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, input logic ordy,
                       output logic acc, output logic xfer, output logic [W:0] obs);
      @(negedge clk);
      bus.in_valid  = iv;
      bus.A         = a;
      bus.B         = b;
      bus.bin       = bi;
      bus.out_ready = ordy;
      #1;
      acc  = iv && bus.in_ready;
      if (acc) exp_q.push_back(model(a, b, bi));
      xfer = bus.out_valid && ordy;
      obs  = {bus.bout, bus.diff};
   endtask

   task automatic test_reset();
      logic acc, xfer;
      logic [W:0] obs;
      rst_n = 1'b0;
      bus.in_valid = 1'b1; bus.A = 8'hFF; bus.B = 8'h00; bus.bin = 1'b0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
      checks++; if (bus.diff !== 8'h00) begin failures++; $display("FAIL rst_diff got=%h want=00", bus.diff); end
      checks++; if (bus.bout !== 1'b0) begin failures++; $display("FAIL rst_bout got=%b want=0", bus.bout); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, obs);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, obs);
      checks++; if (xfer !== 1'b0) begin failures++; $display("FAIL rst_ignored_input got=%b want=0", xfer); end
   endtask

   task automatic test_single();
      logic acc, xfer, all_rdy;
      logic [W:0] obs, exp;
      int lat;
      lat = -1;
      step(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b1, acc, xfer, obs);
      all_rdy = bus.in_ready;
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL single_accept got=%b want=1", acc); end
      for (int t = 1; t < 6; t++) begin
         step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, obs);
         all_rdy = all_rdy & bus.in_ready;
         if (xfer) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL single_extra got=%h want=none", obs); end
            else begin
               exp = exp_q.pop_front();
               if (obs !== exp) begin failures++; $display("FAIL single_data got=%h want=%h", obs, exp); end
            end
            if (lat < 0) begin
               lat = t;
               checks++; if (obs !== 9'h01E) begin failures++; $display("FAIL single_const got=%h want=01e", obs); end
            end
         end
      end
      checks++; if (lat != 2) begin failures++; $display("FAIL single_latency got=%0d want=2", lat); end
      checks++; if (all_rdy !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b want=1", all_rdy); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_borrow();
      logic acc, xfer;
      logic [W:0] obs, exp;
      logic [W:0] lit [2];
      int k;
      k = 0;
      lit[0] = {1'b0, 8'h0E};
`ifdef SUB_PIPE8_SAT_EN
      lit[1] = {1'b1, 8'h00};
`else
      lit[1] = {1'b1, 8'hFF};
`endif
      step(1'b1, 8'h10, 8'h01, 1'b1, 1'b1, acc, xfer, obs);
      step(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, acc, xfer, obs);
      for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
         step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, obs);
         if (xfer) begin
            exp = exp_q.pop_front();
            checks++; if (obs !== exp) begin failures++; $display("FAIL borrow_model got=%h want=%h", obs, exp); end
            if (k < 2) begin
               checks++; if (obs !== lit[k]) begin failures++; $display("FAIL borrow_const%0d got=%h want=%h", k, obs, lit[k]); end
            end
            k++;
         end
      end
      checks++; if (k != 2) begin failures++; $display("FAIL borrow_count got=%0d want=2", k); end
   endtask

   task automatic test_back_to_back();
      logic acc, xfer;
      logic [W:0] obs, exp;
      logic [W-1:0] a, b;
      logic bi;
      int nacc;
      nacc = 0;
      for (int t = 0; t < 18; t++) begin
         a  = W'($urandom_range(0, 255));
         b  = W'($urandom_range(0, 255));
         bi = 1'($urandom_range(0, 1));
         step(t < 16, a, b, bi, 1'b1, acc, xfer, obs);
         if (acc) nacc++;
         checks++;
         if (xfer !== (t >= 2)) begin failures++; $display("FAIL b2b_valid t=%0d got=%b want=%b", t, xfer, (t >= 2)); end
         if (xfer) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra got=%h want=none", obs); end
            else begin
               exp = exp_q.pop_front();
               if (obs !== exp) begin failures++; $display("FAIL b2b_data t=%0d got=%h want=%h", t, obs, exp); end
            end
         end
      end
      checks++; if (nacc != 16) begin failures++; $display("FAIL b2b_accepts got=%0d want=16", nacc); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_left got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      logic acc, xfer;
      logic [W:0] obs, exp, held;
      logic [W-1:0] pa, pb;
      logic pbi;
      int nacc, nout;
      nacc = 0; nout = 0; held = '0;
      pa = W'($urandom_range(0, 255)); pb = W'($urandom_range(0, 255)); pbi = 1'($urandom_range(0, 1));
      for (int t = 0; t < 5; t++) begin
         step(1'b1, pa, pb, pbi, 1'b0, acc, xfer, obs);
         if (acc) begin
            nacc++;
            pa = W'($urandom_range(0, 255)); pb = W'($urandom_range(0, 255)); pbi = 1'($urandom_range(0, 1));
         end
         if (t == 2) held = obs;
         if (t >= 2) begin
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready t=%0d got=%b want=0", t, bus.in_ready); end
         end
         if (t > 2) begin
            checks++; if (obs !== held || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_stable t=%0d got=%h want=%h", t, obs, held); end
         end
      end
      checks++; if (nacc != 2) begin failures++; $display("FAIL bp_accepts got=%0d want=2", nacc); end
      for (int t = 0; t < 40 && (t < 6 || exp_q.size() != 0); t++) begin
         step(t < 6, pa, pb, pbi, 1'b1, acc, xfer, obs);
         if (acc) begin
            nacc++;
            pa = W'($urandom_range(0, 255)); pb = W'($urandom_range(0, 255)); pbi = 1'($urandom_range(0, 1));
         end
         if (xfer) begin
            nout++;
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%h want=none", obs); end
            else begin
               exp = exp_q.pop_front();
               if (obs !== exp) begin failures++; $display("FAIL bp_data got=%h want=%h", obs, exp); end
            end
         end
      end
      checks++; if (nout != nacc || exp_q.size() != 0) begin failures++; $display("FAIL bp_count got=%0d want=%0d", nout, nacc); end
   endtask

   task automatic test_bubble();
      logic acc, xfer;
      logic [W:0] obs, exp, held;
      int nout;
      nout = 0;
      step(1'b1, 8'hA7, 8'h3B, 1'b1, 1'b0, acc, xfer, obs);
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL bub_acc0 got=%b want=1", acc); end
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc, xfer, obs);
      step(1'b1, 8'h22, 8'h81, 1'b0, 1'b0, acc, xfer, obs);
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL bub_acc1 got=%b want=1", acc); end
      held = obs;
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc, xfer, obs);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bub_in_ready got=%b want=0", bus.in_ready); end
      checks++; if (obs !== held) begin failures++; $display("FAIL bub_hold got=%h want=%h", obs, held); end
      for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
         step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, obs);
         if (xfer) begin
            nout++;
            exp = exp_q.pop_front();
            checks++; if (obs !== exp) begin failures++; $display("FAIL bub_data%0d got=%h want=%h", nout, obs, exp); end
         end
      end
      checks++; if (nout != 2) begin failures++; $display("FAIL bub_count got=%0d want=2", nout); end
   endtask

   task automatic test_async_reset();
      logic acc, xfer;
      logic [W:0] obs, exp;
      int lat;
      lat = -1;
      step(1'b1, 8'h44, 8'h12, 1'b0, 1'b0, acc, xfer, obs);
      step(1'b1, 8'h09, 8'hF0, 1'b1, 1'b0, acc, xfer, obs);
      @(posedge clk);
      #2;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL ar_full got=%b%b want=10", bus.out_valid, bus.in_ready); end
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%b want=0", bus.out_valid); end
      checks++; if (bus.diff !== 8'h00 || bus.bout !== 1'b0) begin failures++; $display("FAIL ar_data got=%h want=000", {bus.bout, bus.diff}); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready got=%b want=1", bus.in_ready); end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'hC3, 8'h21, 1'b1, 1'b1, acc, xfer, obs);
      checks++; if (xfer !== 1'b0) begin failures++; $display("FAIL ar_ghost got=%b want=0", xfer); end
      for (int t = 1; t < 6; t++) begin
         step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, obs);
         if (xfer) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL ar_extra got=%h want=none", obs); end
            else begin
               exp = exp_q.pop_front();
               if (obs !== exp) begin failures++; $display("FAIL ar_result got=%h want=%h", obs, exp); end
            end
            if (lat < 0) lat = t;
         end
      end
      checks++; if (lat != 2) begin failures++; $display("FAIL ar_latency got=%0d want=2", lat); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_borrow();
      test_back_to_back();
      test_backpressure();
      test_bubble();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
